// File: rtl/decode_queue.sv
// Instruction decode queue: decodes 32-bit words on push and buffers DEPTH decoded
// entries so fetch and execute can stall independently.
module decode_queue #(
   parameter int DEPTH = 2,
   parameter int IMM_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             mem_phase,
   output logic [9:0]       ikind,
   output logic [2:0]       iclass,
   output logic [2:0]       rg1,
   output logic [2:0]       rg2,
   output logic [7:0]       sim8,
   output logic [IMM_W-1:0] imm,
   output logic             r_we,
   output logic             m_we
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [2:0] CL_ALU = 3'd0;
   localparam logic [2:0] CL_LD  = 3'd1;
   localparam logic [2:0] CL_ST  = 3'd2;
   localparam logic [2:0] CL_B   = 3'd3;
   localparam logic [2:0] CL_JR  = 3'd4;
   localparam logic [2:0] CL_LIL = 3'd5;

   typedef struct packed {
      logic [9:0]       ikind;
      logic [2:0]       iclass;
      logic [2:0]       rg1;
      logic [2:0]       rg2;
      logic [7:0]       sim8;
      logic [IMM_W-1:0] imm;
      logic             r_we;
   } entry_t;

   entry_t          dec;
   entry_t          head;
   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;

   // Handshake: a word transfers on a cycle where valid and ready are both high;
   // flush overrides both directions and nothing moves in that cycle.
   assign out_valid = (count != '0);
   assign in_ready  = flush || (count < CW'(DEPTH)) || out_ready;
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      dec        = '0;
      dec.ikind  = instr[31:22];
      dec.iclass = CL_ALU;
      dec.rg1    = instr[21:19];
      dec.rg2    = instr[18:16];
      dec.sim8   = instr[15:8];
      dec.r_we   = 1'b1;
      casez (instr[31:22])
         10'b1000_101?_01: dec.iclass = CL_LD;
         10'b1000_100?_01: begin
            dec.iclass = CL_ST;
            dec.r_we   = 1'b0;
         end
         10'b1001_0000_11: begin
            dec.iclass = CL_B;
            dec.rg1    = 3'd0;
            dec.rg2    = 3'd0;
            dec.r_we   = 1'b0;
         end
         10'b1111_1111_11: begin
            dec.iclass = CL_JR;
            dec.rg1    = 3'd0;
            dec.sim8   = 8'd0;
            dec.r_we   = 1'b0;
         end
         10'b0110_0110_10: dec.iclass = CL_LIL;
         default:          dec.iclass = CL_ALU;
      endcase
      // LIL carries a byte-swapped 16-bit literal; everything else uses the displacement.
      if (dec.iclass == CL_LIL) begin
         dec.imm       = '0;
         dec.imm[15:0] = {instr[7:0], instr[15:8]};
      end else begin
         dec.imm = {{(IMM_W-8){dec.sim8[7]}}, dec.sim8};
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= dec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head   = out_valid ? mem[rd_ptr] : '0;
   assign ikind  = head.ikind;
   assign iclass = head.iclass;
   assign rg1    = head.rg1;
   assign rg2    = head.rg2;
   assign sim8   = head.sim8;
   assign imm    = head.imm;
   assign r_we   = head.r_we;
   assign m_we   = out_valid && (head.iclass == CL_ST) && mem_phase && !flush;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, FIFO order through pointer wrap,
// memory write strobe qualification, flush and asynchronous reset.
module tb_decode_queue;

   localparam int DEPTH = 2;
   localparam int IMM_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic             mem_phase;
   logic [9:0]       ikind;
   logic [2:0]       iclass;
   logic [2:0]       rg1;
   logic [2:0]       rg2;
   logic [7:0]       sim8;
   logic [IMM_W-1:0] imm;
   logic             r_we;
   logic             m_we;

   int checks = 0;
   int errors = 0;

   decode_queue #(.DEPTH(DEPTH), .IMM_W(IMM_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .mem_phase(mem_phase), .ikind(ikind), .iclass(iclass), .rg1(rg1), .rg2(rg2),
      .sim8(sim8), .imm(imm), .r_we(r_we), .m_we(m_we)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [2:0] c, input logic [2:0] r1,
                           input logic [2:0] r2, input logic [7:0] s8,
                           input logic [15:0] im, input logic we);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_iclass"}, 32'(iclass), 32'(c));
      chk({tag, "_rg1"}, 32'(rg1), 32'(r1));
      chk({tag, "_rg2"}, 32'(rg2), 32'(r2));
      chk({tag, "_sim8"}, 32'(sim8), 32'(s8));
      chk({tag, "_imm"}, 32'(imm), 32'(im));
      chk({tag, "_rwe"}, 32'(r_we), 32'(we));
   endtask

   // Words: LD, LIL, B, ALU (A1, A2), ST; all expected fields hand-decoded.
   localparam logic [31:0] W_LD  = 32'h8B5A_F000;
   localparam logic [31:0] W_LIL = 32'h6698_3412;
   localparam logic [31:0] W_B   = 32'h90C0_0500;
   localparam logic [31:0] W_A1  = 32'h1234_5678;
   localparam logic [31:0] W_A2  = 32'h0000_FF00;
   localparam logic [31:0] W_ST  = 32'h8940_0400;

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; instr = 32'h8B5A_1000; flush = 1'b0;
      out_ready = 1'b0; mem_phase = 1'b1;
      step(); step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_mwe", 32'(m_we), 32'd0);
      chk("rst_imm", 32'(imm), 32'd0);
      chk("rst_ikind", 32'(ikind), 32'd0);
      chk("rst_count", 32'(dut.count), 32'd0);
      in_valid = 1'b0; mem_phase = 1'b0;
      rst_n = 1'b1;
      step();
      chk("post_rst_valid", 32'(out_valid), 32'd0);

      // LD push, visible next cycle
      in_valid = 1'b1; instr = W_LD;
      step();
      in_valid = 1'b0;
      chk_head("ld", 3'd1, 3'd3, 3'd2, 8'hF0, 16'hFFF0, 1'b1);
      chk("ld_ikind", 32'(ikind), 32'h22D);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_imm", 32'(imm), 32'd0);
      chk("empty_iclass", 32'(iclass), 32'd0);

      // LIL then B back-to-back fills the queue
      in_valid = 1'b1; instr = W_LIL;
      step();
      chk_head("lil", 3'd5, 3'd3, 3'd0, 8'h34, 16'h1234, 1'b1);
      chk("lil_ikind", 32'(ikind), 32'h19A);
      instr = W_B;
      step();
      in_valid = 1'b0;
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_count", 32'(dut.count), 32'd2);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_head("b", 3'd3, 3'd0, 3'd0, 8'h05, 16'h0005, 1'b0);

      // Fill again, then simultaneous push/pop while full
      in_valid = 1'b1; instr = W_A1;
      step();
      in_valid = 1'b0;
      chk("full2_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1; instr = W_A2; out_ready = 1'b1;
      #1;
      chk("full_pp_ready", 32'(in_ready), 32'd1);
      step();
      chk("pp1_count", 32'(dut.count), 32'd2);
      chk_head("a1", 3'd0, 3'd6, 3'd4, 8'h56, 16'h0056, 1'b1);
      instr = W_ST;
      step();
      in_valid = 1'b0;
      chk("pp2_count", 32'(dut.count), 32'd2);
      chk_head("a2", 3'd0, 3'd0, 3'd0, 8'hFF, 16'hFFFF, 1'b1);
      step();
      out_ready = 1'b0;
      chk("st_count", 32'(dut.count), 32'd1);
      chk_head("st", 3'd2, 3'd0, 3'd0, 8'h04, 16'h0004, 1'b0);

      // Memory write strobe follows mem_phase only for ST at head
      chk("st_mwe_idle", 32'(m_we), 32'd0);
      mem_phase = 1'b1;
      #1;
      chk("st_mwe_on", 32'(m_we), 32'd1);
      step();
      mem_phase = 1'b0;
      #1;
      chk("st_mwe_off", 32'(m_we), 32'd0);
      chk("st_held", 32'(iclass), 32'd2);
      out_ready = 1'b1; in_valid = 1'b1; instr = W_A1;
      step();
      out_ready = 1'b0; in_valid = 1'b0;
      chk("alu_head", 32'(iclass), 32'd0);
      mem_phase = 1'b1;
      #1;
      chk("alu_mwe", 32'(m_we), 32'd0);
      mem_phase = 1'b0;

      // Arrange ST at head with two entries, then flush with push/pop/mem_phase
      in_valid = 1'b1; instr = W_ST;
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0; in_valid = 1'b1; instr = W_A2;
      step();
      in_valid = 1'b0;
      chk("pre_flush_count", 32'(dut.count), 32'd2);
      chk("pre_flush_iclass", 32'(iclass), 32'd2);
      flush = 1'b1; in_valid = 1'b1; instr = W_LD; mem_phase = 1'b1; out_ready = 1'b1;
      #1;
      chk("flush_ready", 32'(in_ready), 32'd1);
      chk("flush_mwe", 32'(m_we), 32'd0);
      step();
      flush = 1'b0; in_valid = 1'b0; mem_phase = 1'b0; out_ready = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_count", 32'(dut.count), 32'd0);
      chk("flush_imm", 32'(imm), 32'd0);
      step();
      chk("flush_dropped", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-operation
      in_valid = 1'b1; instr = W_LIL;
      step();
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_count", 32'(dut.count), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("arst_after", 32'(out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
